// File: rtl/fifo_wr_rr_arbiter_pkg.sv
// fifo_wr_rr_arbiter shared package: default sizes and index helpers.
// Optional feature macro: FIFO_ARB_PRIO_EN (requester 0 strict priority).
package fifo_arb_pkg;

    localparam int N_REQ_DEF = 4;
    localparam int WIDTH_DEF = 16;

    // Width of a requester index; at least one bit.
    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Round-robin successor with an explicit wrap, so N need not be 2^k.
    function automatic int next_ptr(input int g, input int n);
        return (g >= n - 1) ? 0 : g + 1;
    endfunction

    // (p + k) mod n for p, k < n, without a divider.
    function automatic int wrap_add(input int p, input int k, input int n);
        int s;
        s = p + k;
        return (s >= n) ? s - n : s;
    endfunction

endpackage

// File: rtl/fifo_wr_rr_arbiter_if.sv
// Producer-side and FIFO-write-side bundle of fifo_wr_rr_arbiter.
// Optional feature macro: FIFO_ARB_PRIO_EN (no effect on this interface).
interface fifo_wr_rr_arbiter_if
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int Width = WIDTH_DEF,
    parameter int ID_W  = id_w(N_REQ)
);

    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ*Width-1:0] req_data;
    logic [N_REQ-1:0]       req_ready;
    logic                   full;
    logic                   fifo_w_en;
    logic [Width-1:0]       fifo_in_data;
    logic [ID_W-1:0]        stg_id;
    logic                   stg_valid;

    modport master (
        output req_valid, req_data, full,
        input  req_ready, fifo_w_en, fifo_in_data, stg_id, stg_valid
    );

    modport slave (
        input  req_valid, req_data, full,
        output req_ready, fifo_w_en, fifo_in_data, stg_id, stg_valid
    );

endinterface

// File: rtl/fifo_wr_rr_arbiter_rr_grant.sv
// Combinational round-robin grant picker for fifo_wr_rr_arbiter.
// Optional feature macro: FIFO_ARB_PRIO_EN (requester 0 overrides the search).
module rr_grant
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int ID_W  = id_w(N_REQ)
) (
    input  logic [N_REQ-1:0] req_valid,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  grant_idx,
    output logic             any_valid
);

    logic [N_REQ-1:0] rr_valid;
    logic             found;
    int               idx;

`ifdef FIFO_ARB_PRIO_EN
    // Requester 0 never takes part in the rotating search.
    assign rr_valid = req_valid & {{(N_REQ-1){1'b1}}, 1'b0};
`else
    assign rr_valid = req_valid;
`endif

    assign any_valid = |req_valid;

    // First valid requester at or after ptr, wrapping at N_REQ.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = wrap_add(int'(ptr), k, N_REQ);
            if (!found && rr_valid[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = ID_W'(idx);
            end
        end
`ifdef FIFO_ARB_PRIO_EN
        if (req_valid[0]) begin
            grant     = '0;
            grant[0]  = 1'b1;
            grant_idx = '0;
        end
`endif
    end

endmodule

// File: rtl/fifo_wr_rr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among N_REQ producers.
// Optional feature macro: FIFO_ARB_PRIO_EN (requester 0 strict priority).
module fifo_wr_rr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int Width = WIDTH_DEF,
    parameter int ID_W  = id_w(N_REQ)
) (
    input logic clk,
    input logic rst,
    fifo_wr_rr_arbiter_if.slave bus
);

    logic             stg_valid;
    logic [Width-1:0] stg_data;
    logic [ID_W-1:0]  stg_id;
    logic [ID_W-1:0]  ptr;

    logic [N_REQ-1:0] gnt;
    logic [ID_W-1:0]  gnt_idx;
    logic             any_valid;
    logic             accept;
    logic             drain;
    logic             hs;
    logic             upd_ptr;

    rr_grant #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_grant (
        .req_valid (bus.req_valid),
        .ptr       (ptr),
        .grant     (gnt),
        .grant_idx (gnt_idx),
        .any_valid (any_valid)
    );

    // The stage can take a word when empty or when it is written now.
    assign drain  = stg_valid & ~bus.full;
    assign accept = ~stg_valid | ~bus.full;
    assign hs     = accept & any_valid & ~rst;

`ifdef FIFO_ARB_PRIO_EN
    // Priority grants to requester 0 leave the rotation untouched.
    assign upd_ptr = (gnt_idx != '0);
`else
    assign upd_ptr = 1'b1;
`endif

    assign bus.req_ready    = hs ? gnt : '0;
    assign bus.fifo_w_en    = drain & ~rst;
    assign bus.fifo_in_data = stg_data;
    assign bus.stg_id       = stg_id;
    assign bus.stg_valid    = stg_valid;

    // Stage register and pointer: load on handshake, empty on drain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stg_valid <= 1'b0;
            stg_data  <= '0;
            stg_id    <= '0;
            ptr       <= '0;
        end else if (hs) begin
            stg_valid <= 1'b1;
            stg_data  <= bus.req_data[int'(gnt_idx)*Width +: Width];
            stg_id    <= gnt_idx;
            if (upd_ptr) begin
                ptr <= ID_W'(next_ptr(int'(gnt_idx), N_REQ));
            end
        end else if (drain) begin
            stg_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fifo_wr_rr_arbiter.sv
// Self-checking bench for fifo_wr_rr_arbiter (N_REQ=4, Width=16).
// Expectations follow FIFO_ARB_PRIO_EN when that macro is defined.
module tb_fifo_wr_rr_arbiter;
    import fifo_arb_pkg::*;

    localparam int N = 4;
    localparam int W = 16;
    localparam logic [63:0] DCONT = {16'd4, 16'd3, 16'd2, 16'd1};

    typedef struct {
        logic       f;
        logic [3:0] er;
        logic       ew;
        logic [15:0] ed;
        logic [1:0] eid;
        logic       esv;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fifo_wr_rr_arbiter_if #(.N_REQ(N), .Width(W)) bus();

    fifo_wr_rr_arbiter #(.N_REQ(N), .Width(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk = 0;
    int n_fail = 0;

    logic [3:0]  o_ready;
    logic        o_wen;
    logic        o_sv;
    logic [15:0] o_data;
    logic [1:0]  o_id;

    logic [15:0] pmem [4][64];
    int pwr [4];
    int prd [4];

    logic [15:0] fmem [8];
    int fwp, frp, fcnt;
    bit fifo_on, rd_en;

    int wlog [$];
    int wcyc [$];
    int rlog [$];
    int cyc_n;
    int pushed;

    bit          model_on;
    bit          m_sv;
    logic [15:0] m_data;
    int          m_id, m_nxt;

    vec_t tbl [9];
    int   exp_int [12];

    function automatic void chk(input string nm, input logic [31:0] act,
                                input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    function automatic vec_t mk(input logic f, input logic [3:0] er,
                                input logic ew, input logic [15:0] ed,
                                input logic [1:0] eid, input logic esv);
        vec_t v;
        v.f = f; v.er = er; v.ew = ew;
        v.ed = ed; v.eid = eid; v.esv = esv;
        return v;
    endfunction

    // Winner = valid requester at the smallest cyclic distance from nxt.
    function automatic int pick(input logic [3:0] v, input int nxt);
        int best, bd, dd;
        best = -1;
        bd = N;
`ifdef FIFO_ARB_PRIO_EN
        if (v[0]) return 0;
`endif
        for (int i = 0; i < N; i++) begin
            if (v[i]) begin
                dd = (i - nxt + N) % N;
                if (dd < bd) begin
                    bd = dd;
                    best = i;
                end
            end
        end
        return best;
    endfunction

    task automatic push(input int i, input logic [15:0] val);
        pmem[i][pwr[i] % 64] = val;
        pwr[i]++;
    endtask

    task automatic sample();
        #4;
        o_ready = bus.req_ready;
        o_wen   = bus.fifo_w_en;
        o_sv    = bus.stg_valid;
        o_data  = bus.fifo_in_data;
        o_id    = bus.stg_id;
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
        cyc_n++;
    endtask

    task automatic log_write();
        if (o_wen) begin
            wlog.push_back(int'(o_data));
            wcyc.push_back(cyc_n);
        end
    endtask

    task automatic cyc(input logic [3:0] v, input logic [63:0] d,
                       input logic f);
        bus.req_valid = v;
        bus.req_data  = d;
        bus.full      = f;
        sample();
        log_write();
        next_cyc();
    endtask

    task automatic run_q(input logic f);
        logic [3:0]  v;
        logic [63:0] d;
        logic        ff;
        logic [3:0]  er;
        int          win;
        for (int i = 0; i < N; i++) begin
            v[i] = (pwr[i] != prd[i]);
            d[i*16 +: 16] = v[i] ? pmem[i][prd[i] % 64] : 16'h0;
        end
        ff = fifo_on ? (fcnt == 8) : f;
        bus.req_valid = v;
        bus.req_data  = d;
        bus.full      = ff;
        sample();
        if (model_on) begin
            win = pick(v, m_nxt);
            er = ((!m_sv || !ff) && win >= 0) ? 4'(1 << win) : 4'h0;
            chk("rnd_ready", 32'(o_ready), 32'(er));
            chk("rnd_wen", 32'(o_wen), 32'(m_sv && !ff));
            chk("rnd_sv", 32'(o_sv), 32'(m_sv));
            if (m_sv) begin
                chk("rnd_data", 32'(o_data), 32'(m_data));
                chk("rnd_id", 32'(o_id), m_id);
            end
            if (er != 4'h0) begin
                m_sv = 1'b1;
                m_data = d[win*16 +: 16];
                m_id = win;
`ifdef FIFO_ARB_PRIO_EN
                if (win != 0) m_nxt = (win + 1) % N;
`else
                m_nxt = (win + 1) % N;
`endif
            end else if (m_sv && !ff) begin
                m_sv = 1'b0;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (o_ready[i]) prd[i]++;
        end
        log_write();
        if (fifo_on) begin
            if (rd_en && fcnt > 0) begin
                rlog.push_back(int'(fmem[frp]));
                frp = (frp + 1) % 8;
                fcnt--;
            end
            if (o_wen) begin
                fmem[fwp] = o_data;
                fwp = (fwp + 1) % 8;
                fcnt++;
            end
        end
        next_cyc();
    endtask

    task automatic do_reset();
        bus.req_valid = '0;
        bus.full = 1'b0;
        #2;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        int rem;
        for (int i = 0; i < N; i++) begin
            pwr[i] = 0;
            prd[i] = 0;
        end
        fwp = 0; frp = 0; fcnt = 0;
        fifo_on = 0; rd_en = 0; model_on = 0;
        m_sv = 0; m_data = '0; m_id = 0; m_nxt = 0;
        cyc_n = 0; pushed = 0;

`ifdef FIFO_ARB_PRIO_EN
        tbl[0] = mk(1'b0, 4'h1, 1'b0, 16'd0, 2'd0, 1'b0);
        tbl[1] = mk(1'b0, 4'h1, 1'b1, 16'd1, 2'd0, 1'b1);
        tbl[2] = mk(1'b0, 4'h1, 1'b1, 16'd1, 2'd0, 1'b1);
        tbl[3] = mk(1'b0, 4'h1, 1'b1, 16'd1, 2'd0, 1'b1);
        tbl[4] = mk(1'b0, 4'h1, 1'b1, 16'd1, 2'd0, 1'b1);
        tbl[5] = mk(1'b0, 4'h1, 1'b1, 16'd1, 2'd0, 1'b1);
        tbl[6] = mk(1'b1, 4'h0, 1'b0, 16'd1, 2'd0, 1'b1);
        tbl[7] = mk(1'b1, 4'h0, 1'b0, 16'd1, 2'd0, 1'b1);
        tbl[8] = mk(1'b0, 4'h1, 1'b1, 16'd1, 2'd0, 1'b1);
        idx = 0;
        for (int j = 0; j < 3; j++) exp_int[idx++] = j;
        for (int j = 0; j < 3; j++)
            for (int i = 1; i < N; i++) exp_int[idx++] = 16 * i + j;
`else
        tbl[0] = mk(1'b0, 4'h1, 1'b0, 16'd0, 2'd0, 1'b0);
        tbl[1] = mk(1'b0, 4'h2, 1'b1, 16'd1, 2'd0, 1'b1);
        tbl[2] = mk(1'b0, 4'h4, 1'b1, 16'd2, 2'd1, 1'b1);
        tbl[3] = mk(1'b0, 4'h8, 1'b1, 16'd3, 2'd2, 1'b1);
        tbl[4] = mk(1'b0, 4'h1, 1'b1, 16'd4, 2'd3, 1'b1);
        tbl[5] = mk(1'b0, 4'h2, 1'b1, 16'd1, 2'd0, 1'b1);
        tbl[6] = mk(1'b1, 4'h0, 1'b0, 16'd2, 2'd1, 1'b1);
        tbl[7] = mk(1'b1, 4'h0, 1'b0, 16'd2, 2'd1, 1'b1);
        tbl[8] = mk(1'b0, 4'h4, 1'b1, 16'd2, 2'd1, 1'b1);
        idx = 0;
        for (int j = 0; j < 3; j++)
            for (int i = 0; i < N; i++) exp_int[idx++] = 16 * i + j;
`endif

        // Reset state with all requesters valid
        rst = 1'b1;
        bus.req_valid = 4'hF;
        bus.req_data = DCONT;
        bus.full = 1'b0;
        #3;
        chk("rst_ready", 32'(bus.req_ready), 32'h0);
        chk("rst_wen", 32'(bus.fifo_w_en), 32'h0);
        chk("rst_sv", 32'(bus.stg_valid), 32'h0);
        chk("rst_id", 32'(bus.stg_id), 32'h0);
        chk("rst_data", 32'(bus.fifo_in_data), 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Table: full contention then back-pressure
        for (int r = 0; r < 9; r++) begin
            cyc(4'hF, DCONT, tbl[r].f);
            chk($sformatf("tbl%0d_ready", r), 32'(o_ready), 32'(tbl[r].er));
            chk($sformatf("tbl%0d_wen", r), 32'(o_wen), 32'(tbl[r].ew));
            chk($sformatf("tbl%0d_data", r), 32'(o_data), 32'(tbl[r].ed));
            chk($sformatf("tbl%0d_id", r), 32'(o_id), 32'(tbl[r].eid));
            chk($sformatf("tbl%0d_sv", r), 32'(o_sv), 32'(tbl[r].esv));
        end

        // Reset mid-stream with a word staged
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_wen", 32'(bus.fifo_w_en), 32'h0);
        chk("mid_rst_ready", 32'(bus.req_ready), 32'h0);
        chk("mid_rst_sv", 32'(bus.stg_valid), 32'h0);
        chk("mid_rst_id", 32'(bus.stg_id), 32'h0);
        chk("mid_rst_data", 32'(bus.fifo_in_data), 32'h0);
        @(posedge clk);
        #1;
        chk("mid_rst_hold_ready", 32'(bus.req_ready), 32'h0);
        #1;
        rst = 1'b0;
        #3;
        chk("post_rst_ready", 32'(bus.req_ready), 32'h1);
        chk("post_rst_sv", 32'(bus.stg_valid), 32'h0);
        @(posedge clk);
        #1;
        cyc(4'h0, 64'h0, 1'b0);
        chk("post_rst_wen", 32'(o_wen), 32'h1);
        chk("post_rst_wdata", 32'(o_data), 32'h1);
        cyc(4'h0, 64'h0, 1'b0);

        // Single requester 2: back-to-back 5,6,7
        wlog.delete();
        wcyc.delete();
        push(2, 16'd5);
        push(2, 16'd6);
        push(2, 16'd7);
        repeat (6) run_q(1'b0);
        chk("single_count", wlog.size(), 3);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("single_val%0d", k),
                (k < wlog.size()) ? wlog[k] : -1, 5 + k);
            chk($sformatf("single_cyc%0d", k),
                (k < wcyc.size()) ? wcyc[k] - wcyc[0] : -1, k);
        end
        cyc(4'b1110, {16'h33, 16'h22, 16'h11, 16'h00}, 1'b0);
        chk("ptr3_ready", 32'(o_ready), 32'h8);
        cyc(4'h0, 64'h0, 1'b0);
        chk("ptr3_wdata", 32'(o_data), 32'h33);
        cyc(4'h0, 64'h0, 1'b0);

        // Back-pressure with 0x00AA staged
        push(1, 16'h00AA);
        push(1, 16'h00BB);
        run_q(1'b0);
        chk("bp_accept", 32'(o_ready), 32'h2);
        for (int k = 0; k < 3; k++) begin
            run_q(1'b1);
            chk($sformatf("bp_wen%0d", k), 32'(o_wen), 32'h0);
            chk($sformatf("bp_ready%0d", k), 32'(o_ready), 32'h0);
            chk($sformatf("bp_data%0d", k), 32'(o_data), 32'h00AA);
        end
        run_q(1'b0);
        chk("bp_rel_wen", 32'(o_wen), 32'h1);
        chk("bp_rel_data", 32'(o_data), 32'h00AA);
        chk("bp_rel_ready", 32'(o_ready), 32'h2);
        run_q(1'b0);
        chk("bp_next_wen", 32'(o_wen), 32'h1);
        chk("bp_next_data", 32'(o_data), 32'h00BB);
        chk("bp_next_sv", 32'(o_sv), 32'h1);
        run_q(1'b0);

        // Requesters 0 and 1 both continuously valid
        do_reset();
        for (int k = 0; k < 6; k++) begin
            cyc(4'b0011, {32'h0, 16'h000B, 16'h000A}, 1'b0);
`ifdef FIFO_ARB_PRIO_EN
            chk($sformatf("prio_ready%0d", k), 32'(o_ready), 32'h1);
`else
            chk($sformatf("prio_ready%0d", k), 32'(o_ready),
                (k % 2 == 0) ? 32'h1 : 32'h2);
`endif
        end
        cyc(4'h0, 64'h0, 1'b0);
        cyc(4'h0, 64'h0, 1'b0);

        // Integration with an 8-deep FIFO
        do_reset();
        wlog.delete();
        rlog.delete();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < 3; j++) push(i, 16'(16 * i + j));
        fifo_on = 1;
        rd_en = 0;
        repeat (20) run_q(1'b0);
        rem = 0;
        for (int i = 0; i < N; i++) rem += pwr[i] - prd[i];
        chk("fill_writes", wlog.size(), 8);
        chk("fill_count", fcnt, 8);
        chk("fill_pending", rem, 3);
        chk("fill_stage", 32'(o_sv), 32'h1);
        chk("fill_wen", 32'(o_wen), 32'h0);
        rd_en = 1;
        for (int t = 0; t < 80 && rlog.size() < 12; t++) run_q(1'b0);
        chk("drain_count", rlog.size(), 12);
        for (int k = 0; k < 12; k++) begin
            chk($sformatf("drain%0d", k),
                (k < rlog.size()) ? rlog[k] : -1, exp_int[k]);
        end
        fifo_on = 0;
        rd_en = 0;

        // Randomized traffic against the reference model
        do_reset();
        wlog.delete();
        model_on = 1;
        m_sv = 0; m_data = '0; m_id = 0; m_nxt = 0;
        pushed = 0;
        for (int t = 0; t < 400; t++) begin
            for (int i = 0; i < N; i++) begin
                if (pwr[i] == prd[i] && $urandom_range(0, 1) == 1) begin
                    push(i, 16'($urandom));
                    pushed++;
                end
            end
            run_q($urandom_range(0, 3) == 0);
        end
        repeat (20) run_q(1'b0);
        model_on = 0;
        chk("rnd_total", wlog.size(), pushed);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_wr_rr_arbiter.md
Name: fifo_wr_rr_arbiter

Overview:
- Shares the write port of the synchronous FIFO (`w_en`/`in_data`/`full`) between N_REQ producers.
- Each producer uses a valid/ready handshake. Round-robin grant; the winning word goes into a one-entry output stage that drives the FIFO write port.
- Sits directly in front of the FIFO write side; the read side is untouched.

Parameters:
- N_REQ, 4, number of requesters (>= 2; non-power-of-2 allowed)
- Width, 16, data width; must equal the FIFO Width
- ID_W, $clog2(N_REQ), width of the source index

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  N_REQ  bit i = requester i has a word
- req_data  in  N_REQ*Width  requester i data at [i*Width +: Width]
- req_ready  out  N_REQ  one-hot or zero; bit i = requester i word accepted this cycle
- full  in  1  FIFO full flag
- fifo_w_en  out  1  FIFO write enable
- fifo_in_data  out  Width  FIFO write data
- stg_id  out  ID_W  source index of the word in the stage
- stg_valid  out  1  stage holds a word

Behaviour:
- State:
  - stage register: stg_valid, stg_data, stg_id
  - round-robin pointer ptr (0..N_REQ-1)
- Reset (async, immediate): stg_valid=0, stg_data=0, stg_id=0, ptr=0. While rst=1, req_ready=0 and fifo_w_en=0.
- Write side (combinational):
  - fifo_w_en = stg_valid & ~full
  - fifo_in_data = stg_data
- Accept condition: accept = ~stg_valid | ~full. The stage is empty or is being written this cycle.
- Grant: the first i with req_valid[i]=1, searching from ptr upward and wrapping modulo N_REQ.
  - req_ready[g] = accept & any(req_valid); all other bits 0.
  - ready does not depend on valid of other cycles.
- Handshake cycle (req_ready[g]=1): stg_data<=req_data[g], stg_id<=g, stg_valid<=1, ptr<=(g+1) mod N_REQ.
  - For N_REQ not a power of 2, wrap explicitly at N_REQ-1 -> 0.
- No handshake:
  - stage drained (fifo_w_en=1) -> stg_valid<=0.
  - otherwise the stage holds; ptr is unchanged.
- Latency and throughput:
  - Word accepted at edge k appears on fifo_w_en in cycle k+1 at the earliest.
  - Sustained rate 1 word/cycle while full=0.
- full=1 with stg_valid=1: stage frozen, fifo_w_en=0, all req_ready=0. No data loss or duplication.
- full falls: the stage writes and a new grant is accepted in the same cycle.
- Simultaneous drain and accept: the stage is replaced, stg_valid stays 1.
- Protocol: a requester holds valid and data stable until ready. A dropped valid before grant is simply not considered. No fairness violation: every continuously valid requester is granted within N_REQ grants.
- Reset asserted mid-operation: the staged word is discarded. The FIFO is reset by the same rst, so no half write remains.

Optional Feature:
- Macro: FIFO_ARB_PRIO_EN.
- Defined: requester 0 is strict-priority. If req_valid[0]=1 it wins regardless of ptr, and ptr is not updated on requester-0 grants. Requesters 1..N_REQ-1 round-robin among themselves when req_valid[0]=0.
- Undefined: pure round-robin over all N_REQ requesters, as above.

Decomposition:
- Package fifo_arb_pkg:
  - default N_REQ and Width
  - function clog2-based ID_W
  - function next_ptr(g) implementing the modulo-N_REQ wrap
- Sub-module rr_grant: combinational. Inputs req_valid and ptr; outputs grant one-hot, grant index and any_valid. The prio override is applied inside rr_grant under FIFO_ARB_PRIO_EN.
- The top holds the stage register, ptr and the handshake logic.

Test Plan:
- Reset: pulse rst=1 mid-stream with stg_valid=1 -> fifo_w_en=0, req_ready=0, stg_valid=0, ptr=0 immediately (before the next clk edge).
- Full contention: 4 requesters continuously valid with data i+1, full=0 -> fifo_in_data sequence 1,2,3,4,1,2,...; one write per cycle; stg_id 0,1,2,3,0.
- Single requester: only req 2 valid with data 5,6,7 -> back-to-back writes 5,6,7; ptr=3 after the last.
- Back-pressure: stage holds 0x00AA, full=1 for 3 cycles -> fifo_w_en=0 and req_ready=0 for 3 cycles. Full drops -> 0x00AA written and the next word accepted in that same cycle.
- Integration with FIFO (Depth 8, Width 16):
  - Setup: 4 requesters push 3 words each (data 0x10*i+j), no reads.
  - Fill phase: exactly 8 writes, full=1, the remaining words stalled without loss.
  - Drain phase: enable r_en -> all 12 words come out in round-robin order.
- FIFO_ARB_PRIO_EN: req 0 and req 1 continuously valid -> only req 0 granted. With the macro undefined, grants alternate 0,1,0,1.
